// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> DONE; the memory is driven only during ACCESS.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | pick a winner round-robin, latch its request fields
//   ACCESS | drive latched address/data/mask to memory, capture m_rdata
//   DONE   | one-cycle ack to the winner, update last-granted pointer
module mem_arbiter #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [31:0]           a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_wmask,
    output logic                  a_ack,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [31:0]           b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_wmask,
    output logic                  b_ack,
    output logic [DATA_W-1:0]     b_rdata,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_wr_en,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wmask,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_b;
    logic                r_sel_b;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]   r_rdata_a;
    logic [DATA_W-1:0]   r_rdata_b;
    logic                w_any_req;
    logic                w_win_b;
    logic                w_grant;
    logic                w_unused_lsb;

    // Byte-offset bits are don't-care: accesses are always whole words.
    assign w_unused_lsb = ^{a_addr[2:0], b_addr[2:0]};

    assign w_any_req = a_req | b_req;
    assign w_win_b   = (a_req & b_req) ? ~r_last_b : b_req;
    assign w_grant   = (r_state == S_IDLE) & w_any_req;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last_b  <= 1'b1;
            r_sel_b   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (w_grant) begin
                r_sel_b <= w_win_b;
                if (w_win_b) begin
                    r_we    <= b_we;
                    r_addr  <= b_addr[ADDR_W+2:3];
                    r_wdata <= b_wdata;
                    r_wmask <= b_wmask;
                end else begin
                    r_we    <= a_we;
                    r_addr  <= a_addr[ADDR_W+2:3];
                    r_wdata <= a_wdata;
                    r_wmask <= a_wmask;
                end
            end
            // Capture happens for writes too, so a write returns the old word.
            if (r_state == S_ACCESS) begin
                if (r_sel_b) r_rdata_b <= m_rdata;
                else         r_rdata_a <= m_rdata;
            end
            if (r_state == S_DONE) begin
                r_last_b <= r_sel_b;
            end
        end
    end

    always_comb begin
        m_addr  = '0;
        m_wr_en = 1'b0;
        m_wdata = '0;
        m_wmask = '0;
        a_ack   = 1'b0;
        b_ack   = 1'b0;
        if (r_state == S_ACCESS) begin
            m_addr  = r_addr;
            m_wr_en = r_we & (|r_wmask);
            m_wdata = r_wdata;
            m_wmask = r_wmask;
        end
        if (r_state == S_DONE) begin
            a_ack = ~r_sel_b;
            b_ack = r_sel_b;
        end
    end

    assign a_rdata = r_rdata_a;
    assign b_rdata = r_rdata_b;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural byte-masked memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, b_addr;
    logic [63:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [7:0]  a_wmask, b_wmask;
    logic        a_ack, b_ack;
    logic [28:0] m_addr;
    logic        m_wr_en;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_wmask;

    logic [63:0] mem [16];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(29), .DATA_W(64)) dut (
        .clk(clk), .nrst(nrst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_wmask(a_wmask), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_wmask(b_wmask), .b_ack(b_ack), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_wr_en(m_wr_en), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata)
    );

    assign m_rdata = mem[m_addr[3:0]];

    always @(posedge clk) begin
        if (m_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (m_wmask[i]) mem[m_addr[3:0]][i*8 +: 8] <= m_wdata[i*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_wmask = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_wmask = 0;
    endtask

    // Called one tick after a rising edge with the arbiter idle and the other port quiet.
    task automatic run_txn(input string tag, input bit is_b, input bit we,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [7:0] mask, input logic [63:0] exp_rd);
        logic exp_wr;
        exp_wr = we && (mask != 8'h00);
        if (is_b) begin
            b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; b_wmask = mask;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; a_wmask = mask;
        end
        step();
        check({tag, "_maddr"}, 64'(m_addr), 64'(addr[31:3]));
        check({tag, "_wren"}, 64'(m_wr_en), 64'(exp_wr));
        check({tag, "_wdata"}, m_wdata, wdata);
        check({tag, "_wmask"}, 64'(m_wmask), 64'(mask));
        check({tag, "_early_ack"}, 64'(is_b ? b_ack : a_ack), 64'd0);
        // Changing the request fields now must not disturb the latched transaction.
        if (is_b) begin
            b_we = ~we; b_addr = addr ^ 32'h40; b_wdata = ~wdata; b_wmask = ~mask;
        end else begin
            a_we = ~we; a_addr = addr ^ 32'h40; a_wdata = ~wdata; a_wmask = ~mask;
        end
        step();
        check({tag, "_ack"}, 64'(is_b ? b_ack : a_ack), 64'd1);
        check({tag, "_other_ack"}, 64'(is_b ? a_ack : b_ack), 64'd0);
        check({tag, "_rdata"}, is_b ? b_rdata : a_rdata, exp_rd);
        check({tag, "_done_wren"}, 64'(m_wr_en), 64'd0);
        clear_inputs();
        step();
        check({tag, "_ack_pulse"}, 64'(is_b ? b_ack : a_ack), 64'd0);
    endtask

    initial begin
        int ack_cyc[$];
        bit ack_who[$];
        int cnt;

        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        clear_inputs();
        nrst = 0;
        repeat (2) step();
        check("rst_a_ack", 64'(a_ack), 64'd0);
        check("rst_b_ack", 64'(b_ack), 64'd0);
        check("rst_a_rdata", a_rdata, 64'd0);
        check("rst_b_rdata", b_rdata, 64'd0);
        check("rst_wren", 64'(m_wr_en), 64'd0);
        check("rst_maddr", 64'(m_addr), 64'd0);
        nrst = 1;

        run_txn("a_wr", 0, 1, 32'h10, 64'h1122334455667788, 8'hFF, 64'd0);
        run_txn("a_rd", 0, 0, 32'h10, 64'h0, 8'hFF, 64'h1122334455667788);
        run_txn("b_wr", 1, 1, 32'h18, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'd0);
        run_txn("b_rd", 1, 0, 32'h1B, 64'h0, 8'h00, 64'h00000000FFFFFFFF);
        check("a_rdata_hold", a_rdata, 64'h1122334455667788);
        run_txn("a_wr_nomask", 0, 1, 32'h10, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h1122334455667788);
        run_txn("a_rd_after_nomask", 0, 0, 32'h10, 64'h0, 8'h00, 64'h1122334455667788);

        // A request pulse that falls between edges is never sampled.
        a_req = 1; a_we = 1; a_addr = 32'h28; a_wdata = 64'h55; a_wmask = 8'hFF;
        #3;
        clear_inputs();
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (a_ack || b_ack || m_wr_en) cnt++;
        end
        check("short_pulse_no_txn", 64'(cnt), 64'd0);

        // Both ports requesting continuously out of reset.
        nrst = 0;
        a_req = 1; a_addr = 32'h10; b_req = 1; b_addr = 32'h18;
        step();
        nrst = 1;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (a_ack && b_ack) check("rr_double_ack", 64'd1, 64'd0);
            if (a_ack) begin ack_cyc.push_back(c); ack_who.push_back(1'b0); end
            if (b_ack) begin ack_cyc.push_back(c); ack_who.push_back(1'b1); end
        end
        clear_inputs();
        check("rr_ack_count", 64'(ack_cyc.size()), 64'd5);
        foreach (ack_cyc[i]) begin
            check($sformatf("rr_cycle%0d", i), 64'(ack_cyc[i]), 64'(2 + 3 * i));
            check($sformatf("rr_who%0d", i), 64'(ack_who[i]), 64'(i % 2));
        end
        step();

        // Reset in the middle of an A write aborts it cleanly.
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 64'hCAFEF00DCAFEF00D; a_wmask = 8'hFF;
        step();
        check("abort_wren_before", 64'(m_wr_en), 64'd1);
        #2;
        nrst = 0;
        #1;
        check("abort_wren_async", 64'(m_wr_en), 64'd0);
        check("abort_maddr", 64'(m_addr), 64'd0);
        check("abort_wdata", m_wdata, 64'd0);
        clear_inputs();
        step();
        check("abort_no_ack1", 64'(a_ack), 64'd0);
        step();
        check("abort_no_ack2", 64'(a_ack), 64'd0);
        nrst = 1;
        run_txn("post_abort_rd", 0, 0, 32'h20, 64'h0, 8'hFF, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
